// File: rtl/count_arbiter_pkg.sv
// Shared definitions for the count_arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter FSM state encoding and the default counter width and
// requester count used by the interface and the top module.
package count_arbiter_pkg;

  localparam int DEF_N   = 16;  // counter and interval-length width
  localparam int DEF_REQ = 4;   // number of requesters (2..8)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/count_arbiter_if.sv
// Request/grant bundle between timing clients and the count arbiter.
// Latency: n/a (wiring only).
// Backpressure: a client holds req high until its done pulse; dropping it early aborts.
//
// Signals:
//   req   - per-requester request
//   len   - packed interval lengths, requester i at [i*N +: N]
//   gnt   - one-hot grant, zero when idle
//   done  - one-cycle completion pulse to the granted requester
//   busy  - arbiter is in LOAD, RUN or DONE
//   count - shared counter value, for observation
// master = client side, slave = arbiter side.
interface count_arbiter_if
  import count_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int REQ = DEF_REQ
);

  logic [REQ-1:0]   req;
  logic [REQ*N-1:0] len;
  logic [REQ-1:0]   gnt;
  logic [REQ-1:0]   done;
  logic             busy;
  logic [N-1:0]     count;

  modport master (
    output req, len,
    input  gnt, done, busy, count
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, count
  );

endinterface

// File: rtl/interval_counter.sv
// N-bit up counter with synchronous clear/enable/hold and a terminal flag.
// Latency: count updates one cycle after clr/en; term is combinational on count.
// Backpressure: none; the owner stops counting by dropping en.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clr      - force count to 0 on the next edge (wins over en)
//   en       - increment count on the next edge
//   lat_len  - latched interval length the terminal flag compares against
//   count    - current value
//   term     - high when count == lat_len-1
module interval_counter
  import count_arbiter_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] lat_len,
  output logic [N-1:0] count,
  output logic         term
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + N'(1);
    end
  end

  // Only meaningful while RUN holds a non-zero lat_len.
  assign term = (count == (lat_len - N'(1)));

endmodule

// File: rtl/count_arbiter.sv
// Round-robin scheduler sharing one interval counter among REQ requesters.
// Latency: grant one edge after req is seen in IDLE; done pulse len+1 edges after the grant edge.
// Backpressure: requester holds req until done; a dropped req aborts the interval with no done.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   bus      - count_arbiter_if.slave: req/len in, gnt/done/busy/count out
// All outputs are registered.
module count_arbiter
  import count_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int REQ = DEF_REQ
) (
  input logic            clk,
  input logic            rst,
  count_arbiter_if.slave bus
);

  localparam int LW = (REQ > 1) ? $clog2(REQ) : 1;

  state_t         state_q, state_d;
  logic [REQ-1:0] gnt_q, gnt_d;
  logic [REQ-1:0] done_q, done_d;
  logic           busy_q, busy_d;
  logic [LW-1:0]  gidx_q, gidx_d;
  logic [LW-1:0]  last_q, last_d;
  logic [N-1:0]   lat_len_q, lat_len_d;

  logic           cnt_clr;
  logic           cnt_en;
  logic           term;
  logic [N-1:0]   count;
  logic [N-1:0]   win_len;
  logic           abort;
  logic           rel;
  logic [LW:0]    pick;

  // Returns {valid, index}. The request vector is doubled so the search can
  // start at last+1 and run ascending with wrap without a modulo on the
  // vector; scanning offsets from far to near lets the nearest one win.
  function automatic logic [LW:0] rr_pick(input logic [REQ-1:0] r,
                                          input logic [LW-1:0]  last);
    logic [2*REQ-1:0] dbl;
    logic [LW:0]      res;
    dbl = {r, r};
    res = '0;
    for (int i = REQ; i >= 1; i--) begin
      if (dbl[int'(last) + i]) begin
        res = {1'b1, LW'((int'(last) + i) % REQ)};
      end
    end
    return res;
  endfunction

  assign pick    = rr_pick(bus.req, last_q);
  assign win_len = bus.len[gidx_q*N +: N];
  assign abort   = !bus.req[gidx_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    lat_len_d = lat_len_q;
    done_d    = '0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    rel       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (pick[LW]) begin
          state_d = ST_LOAD;
          gidx_d  = pick[LW-1:0];
          gnt_d   = REQ'(1) << pick[LW-1:0];
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_clr = 1'b1;
        if (abort) begin
          rel = 1'b1;
        end else begin
          lat_len_d = win_len;
          if (win_len == '0) begin
            state_d = ST_DONE;
            done_d  = gnt_q;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          rel = 1'b1;
        end else if (term) begin
          // Count holds at lat_len-1 through DONE.
          state_d = ST_DONE;
          done_d  = gnt_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        rel = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Normal completion and abort both hand priority away from the
    // requester that just held the counter.
    if (rel) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      busy_d  = 1'b0;
      last_d  = gidx_q;
      cnt_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      gidx_q    <= '0;
      last_q    <= LW'(REQ - 1);
      lat_len_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      lat_len_q <= lat_len_d;
    end
  end

  interval_counter #(.N(N)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .lat_len (lat_len_q),
    .count   (count),
    .term    (term)
  );

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count;

endmodule

// File: tb/tb_count_arbiter.sv
// Scoreboard bench for count_arbiter with a timeline-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_count_arbiter;

  localparam int N   = 4;
  localparam int REQ = 4;

  typedef struct {
    logic [REQ-1:0] gnt;
    logic [REQ-1:0] done;
    logic           busy;
    logic [N-1:0]   count;
  } lvl_t;

  typedef struct {
    int kind;  // 0 grant, 1 done
    int who;
    int cyc;
  } ev_t;

  logic clk;
  logic rst;

  count_arbiter_if #(.N(N), .REQ(REQ)) bus ();

  count_arbiter #(.N(N), .REQ(REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  int   ngrant = 0;
  int   ndone  = 0;
  lvl_t lvl_q[$];
  ev_t  ev_q[$];

  // Reference model state: an interval is described by who holds the
  // counter, the edge it was granted on and its length.
  bit m_act  = 1'b0;
  int m_g    = 0;
  int m_k    = 0;
  int m_len  = 0;
  int m_last = REQ - 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic int rr_ref(input logic [REQ-1:0] r, input int last);
    for (int o = 1; o <= REQ; o++) begin
      if (r[(last + o) % REQ]) return (last + o) % REQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    lvl_t l;
    bit   dn;
    int   off;
    dn = 1'b0;
    cyc++;
    if (rst) begin
      m_act  = 1'b0;
      m_last = REQ - 1;
    end else if (!m_act) begin
      if (bus.req != '0) begin
        m_g   = rr_ref(bus.req, m_last);
        m_act = 1'b1;
        m_k   = cyc;
        m_len = 0;
        ev_q.push_back('{0, m_g, cyc});
      end
    end else if (cyc == m_k + 1 || cyc <= m_k + 1 + m_len) begin
      // Length is taken one edge after the grant; the interval then
      // finishes len edges later unless its requester lets go first.
      if (cyc == m_k + 1) m_len = int'(bus.len[m_g*N +: N]);
      if (!bus.req[m_g]) begin
        m_act  = 1'b0;
        m_last = m_g;
      end else if (cyc == m_k + 1 + m_len) begin
        dn = 1'b1;
        ev_q.push_back('{1, m_g, cyc});
      end
    end else begin
      m_act  = 1'b0;
      m_last = m_g;
    end

    l.gnt  = m_act ? REQ'(1 << m_g) : '0;
    l.done = dn ? REQ'(1 << m_g) : '0;
    l.busy = m_act;
    l.count = '0;
    if (m_act && cyc > m_k) begin
      off = cyc - m_k - 1;
      if (off < m_len) l.count = N'(off);
      else             l.count = (m_len == 0) ? '0 : N'(m_len - 1);
    end
    lvl_q.push_back(l);
  end

  logic [REQ-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    lvl_t l;
    ev_t  ev;
    if (cyc > 0) begin
      if (lvl_q.size() == 0) begin
        chk("level_queue_empty", 0, 1);
      end else begin
        l = lvl_q.pop_front();
        chk("gnt", int'(bus.gnt), int'(l.gnt));
        chk("done", int'(bus.done), int'(l.done));
        chk("busy", int'(bus.busy), int'(l.busy));
        chk("count", int'(bus.count), int'(l.count));
      end
      if (bus.gnt != '0 && prev_gnt == '0) begin
        ngrant++;
        if (ev_q.size() == 0) begin
          chk("unexpected_grant", int'(bus.gnt), 0);
        end else begin
          ev = ev_q.pop_front();
          chk("grant_event_kind", 0, ev.kind);
          chk("grant_who", int'(bus.gnt), 1 << ev.who);
          chk("grant_cycle", cyc, ev.cyc);
        end
      end
      if (bus.done != '0) begin
        ndone++;
        if (ev_q.size() == 0) begin
          chk("unexpected_done", int'(bus.done), 0);
        end else begin
          ev = ev_q.pop_front();
          chk("done_event_kind", 1, ev.kind);
          chk("done_who", int'(bus.done), 1 << ev.who);
          chk("done_cycle", cyc, ev.cyc);
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int idx, input int budget);
    int n;
    n = 0;
    while (!bus.done[idx] && n < budget) begin
      step();
      n++;
    end
    chk("wait_done", int'(bus.done[idx]), 1);
    bus.req[idx] = 1'b0;
  endtask

  task automatic wait_any_done(input int budget);
    int n;
    n = 0;
    while (bus.done == '0 && n < budget) begin
      step();
      n++;
    end
    chk("wait_any_done", int'(bus.done != '0), 1);
  endtask

  task automatic wait_count(input int v, input int budget);
    int n;
    n = 0;
    while (int'(bus.count) != v && n < budget) begin
      step();
      n++;
    end
    chk("wait_count", int'(bus.count), v);
  endtask

  initial begin
    logic [REQ-1:0] r;
    rst     = 1'b1;
    bus.req = '0;
    bus.len = '0;
    repeat (3) step();
    rst = 1'b0;

    // Fairness: all requesters, len 2 each, five completions.
    for (int i = 0; i < REQ; i++) bus.len[i*N +: N] = N'(2);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_any_done(20);
      if (i == 4) bus.req = '0;
      step();
    end
    repeat (2) step();

    // Single request, len 5.
    bus.len[0*N +: N] = N'(5);
    bus.req = 4'b0001;
    wait_done(0, 20);
    repeat (3) step();

    // Zero length.
    bus.len[2*N +: N] = N'(0);
    bus.req = 4'b0100;
    wait_done(2, 10);
    repeat (3) step();

    // Abort at count 3 while requester 2 waits.
    bus.len[1*N +: N] = N'(10);
    bus.len[2*N +: N] = N'(3);
    bus.req = 4'b0010;
    step();
    bus.req[2] = 1'b1;
    wait_count(3, 20);
    bus.req[1] = 1'b0;
    wait_done(2, 20);
    repeat (3) step();

    // Reset during RUN, then requester 0 must win over 3.
    bus.len[0*N +: N] = N'(10);
    bus.len[3*N +: N] = N'(1);
    bus.req = 4'b0001;
    wait_count(7, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 4'b1001;
    wait_done(0, 30);
    wait_done(3, 30);
    repeat (3) step();

    // Longest interval the 4-bit counter allows.
    bus.len[1*N +: N] = N'(15);
    bus.req = 4'b0010;
    wait_done(1, 40);
    repeat (3) step();

    // Random traffic: joins, withdrawals, len churn and rare resets.
    for (int c = 0; c < 3000; c++) begin
      r = bus.req;
      for (int i = 0; i < REQ; i++) begin
        if (!r[i]) begin
          if ($urandom_range(3) == 0) begin
            r[i] = 1'b1;
            bus.len[i*N +: N] = N'($urandom_range(15));
          end
        end else if (bus.done[i]) begin
          if ($urandom_range(1) == 0) r[i] = 1'b0;
        end else if ($urandom_range(63) == 0) begin
          r[i] = 1'b0;
        end
        if ($urandom_range(7) == 0) bus.len[i*N +: N] = N'($urandom_range(15));
      end
      bus.req = r;
      rst = ($urandom_range(499) == 0);
      step();
    end

    rst = 1'b0;
    bus.req = '0;
    repeat (25) step();
    chk("events_left", ev_q.size(), 0);
    chk("grants_seen", int'(ngrant > 50), 1);
    chk("dones_seen", int'(ndone > 20), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
